// File: rtl/gpu_pkg.sv
// gpu_pkg: shared VRAM write queue types and address width.
package gpu_pkg;
  localparam int VRAM_ADDR_WIDTH = 12;
  typedef struct packed {
    logic                       fill;
    logic [VRAM_ADDR_WIDTH-1:0] addr;
    logic [7:0]                 data;
    logic [VRAM_ADDR_WIDTH-1:0] count;
  } vram_wq_entry_t;
  typedef enum logic {IDLE, ACTIVE} vram_wq_state_t;
endpackage

// File: rtl/vram_wq_fifo.sv
// vram_wq_fifo: synchronous FIFO of write-queue entries with a registered head.
module vram_wq_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  vram_wq_entry_t din,
  output vram_wq_entry_t head,
  output logic           full,
  output logic           empty
);
  localparam int AW = $clog2(DEPTH);
  vram_wq_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    full = count == (AW+1)'(DEPTH);
    empty = count == '0;
    head = mem[rd_ptr];
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/vram_write_queue.sv
// vram_write_queue: buffers CPU VRAM writes/fills and replays them during writable windows.
module vram_write_queue
  import gpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [VRAM_ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]                 req_data,
  input  logic                       req_fill,
  input  logic [VRAM_ADDR_WIDTH-1:0] req_len,
  input  logic                       writable,
  output logic [7:0]                 data,
  output logic [VRAM_ADDR_WIDTH-1:0] address,
  output logic                       write_enable,
  output logic                       busy
);
  vram_wq_state_t state, state_next;
  vram_wq_entry_t entry_in, head;
  logic [VRAM_ADDR_WIDTH-1:0] op_addr, remaining;
  logic [7:0] op_data;
  logic push, pop, full, empty, commit, last;
  vram_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (entry_in),
    .head (head),
    .full (full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_addr <= '0;
      op_data <= '0;
      remaining <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        op_addr <= head.addr;
        op_data <= head.data;
        remaining <= head.fill ? head.count : VRAM_ADDR_WIDTH'(1);
      end else if (commit) begin
        op_addr <= op_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end
  // Zero-length fills are swallowed at the handshake so the engine never sees an empty op.
  always_comb begin
    entry_in = '{fill: req_fill, addr: req_addr, data: req_data,
                 count: req_fill ? req_len : VRAM_ADDR_WIDTH'(1)};
    push = req_valid && req_ready && !(req_fill && req_len == '0);
    commit = state == ACTIVE && writable;
    last = remaining == VRAM_ADDR_WIDTH'(1);
    pop = !empty && (state == IDLE || (commit && last));
    state_next = state == IDLE ? (empty ? IDLE : ACTIVE)
               : (commit && last && empty ? IDLE : ACTIVE);
  end
  always_comb begin
    write_enable = state == ACTIVE && writable;
    address = op_addr;
    data = op_data;
    busy = state == ACTIVE || !empty;
    req_ready = !full && !rst;
  end
endmodule

// File: tb/tb_vram_write_queue.sv
// tb_vram_write_queue: randomized and directed checks against a byte-level write model.
module tb_vram_write_queue;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 1, req_valid = 0, req_fill = 0, writable = 0;
  logic [11:0] req_addr = 0, req_len = 0, address;
  logic [7:0] req_data = 0, data;
  logic req_ready, write_enable, busy;
  int checks = 0, errors = 0, strobes = 0, run = 0, last_run = 0;
  bit rand_wr = 0;
  logic [19:0] exp_q[$];

  vram_write_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_fill(req_fill), .req_len(req_len),
    .writable(writable), .data(data), .address(address),
    .write_enable(write_enable), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rand_wr) begin
      #1 writable = 1'($urandom_range(0, 1));
    end

  // Model: every accepted request expands into its bytes; VRAM must see exactly that sequence.
  always @(negedge clk) begin
    logic [19:0] e;
    int n;
    if (write_enable) begin
      strobes++;
      run++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe: unexpected write addr=%h data=%h, none pending", address, data);
      end else begin
        e = exp_q.pop_front();
        if ({address, data} !== e || writable !== 1'b1) begin
          errors++;
          $display("FAIL strobe: got addr=%h data=%h writable=%b, want addr=%h data=%h writable=1",
                   address, data, writable, e[19:8], e[7:0]);
        end
      end
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
    if (rst) exp_q.delete();
    else if (req_valid && req_ready) begin
      n = req_fill ? int'(req_len) : 1;
      for (int i = 0; i < n; i++) exp_q.push_back({12'(int'(req_addr) + i), req_data});
    end
  end

  task automatic send(input logic [11:0] a, input logic [7:0] d, input logic f, input logic [11:0] l);
    int n = 0;
    req_addr = a; req_data = d; req_fill = f; req_len = l; req_valid = 1;
    @(negedge clk);
    while (!req_ready && n < 3000) begin n++; @(negedge clk); end
    checks++;
    if (!req_ready) begin errors++; $display("FAIL send: req_ready=%b, want 1 within bound", req_ready); end
    @(posedge clk); #1 req_valid = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin n++; @(negedge clk); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s idle: busy=%b, want 0", tag, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({req_ready, write_enable, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_hold: ready/we/busy=%b, want 000", {req_ready, write_enable, busy});
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    checks++;
    if ({req_ready, write_enable, busy, address, data} !== {3'b100, 20'h0}) begin
      errors++;
      $display("FAIL reset_out: ready=%b we=%b busy=%b addr=%h data=%h, want 1 0 0 000 00",
               req_ready, write_enable, busy, address, data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int s0 = strobes;
    writable = 1;
    req_addr = 12'h205; req_data = 8'hA5; req_fill = 0; req_len = 0; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    @(negedge clk);
    checks++;
    if ({write_enable, busy} !== 2'b01) begin
      errors++; $display("FAIL single_e0: we/busy=%b, want 01", {write_enable, busy});
    end
    @(negedge clk);
    checks++;
    if ({write_enable, address, data} !== {1'b1, 12'h205, 8'hA5}) begin
      errors++; $display("FAIL single_e1: we=%b addr=%h data=%h, want 1 205 a5", write_enable, address, data);
    end
    @(negedge clk);
    checks++;
    if ({write_enable, busy} !== 2'b00) begin
      errors++; $display("FAIL single_e2: we/busy=%b, want 00", {write_enable, busy});
    end
    wait_idle("single");
    checks++;
    if (strobes - s0 != 1) begin errors++; $display("FAIL single_count: %0d strobes, want 1", strobes - s0); end
  endtask

  task automatic test_fill_clear();
    int s0 = strobes;
    writable = 1;
    send(12'h400, 8'h00, 1, 12'd960);
    wait_idle("clear");
    checks++;
    if (strobes - s0 != 960 || last_run != 960) begin
      errors++; $display("FAIL clear: %0d strobes run %0d, want 960 run 960", strobes - s0, last_run);
    end
  endtask

  task automatic test_stall();
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int s0 = strobes;
    writable = 0;
    send(12'h600, 8'h3C, 1, 12'd4);
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) begin
      writable = 1'(pat[i]);
      @(negedge clk);
      checks++;
      if (write_enable !== 1'(pat[i])) begin
        errors++; $display("FAIL stall_we[%0d]: we=%b, want %0d", i, write_enable, pat[i]);
      end
      @(posedge clk); #1;
    end
    writable = 0;
    wait_idle("stall");
    checks++;
    if (strobes - s0 != 4) begin errors++; $display("FAIL stall_count: %0d strobes, want 4", strobes - s0); end
  endtask

  // One entry is taken by the engine, so DEPTH+1 requests fit before the queue refuses.
  task automatic test_backpressure();
    int s0 = strobes;
    writable = 0;
    for (int i = 0; i < DEPTH + 1; i++) send(12'($urandom), 8'($urandom), 0, 0);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full: req_ready=%b, want 0", req_ready); end
    @(posedge clk); #1 writable = 1;
    for (int i = DEPTH + 1; i < 12; i++) send(12'($urandom), 8'($urandom), 0, 0);
    wait_idle("bp");
    checks++;
    if (strobes - s0 != 12 || last_run != 12) begin
      errors++; $display("FAIL bp_drain: %0d strobes run %0d, want 12 run 12", strobes - s0, last_run);
    end
  endtask

  task automatic test_wrap();
    int s0 = strobes;
    writable = 1;
    send(12'hFFE, 8'($urandom), 1, 12'd3);
    wait_idle("wrap");
    checks++;
    if (strobes - s0 != 3) begin errors++; $display("FAIL wrap_count: %0d strobes, want 3", strobes - s0); end
  endtask

  task automatic test_zero_len();
    int s0 = strobes;
    writable = 1;
    send(12'($urandom), 8'($urandom), 1, 12'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, req_ready} !== 2'b01) begin
        errors++; $display("FAIL zero_len[%0d]: busy/ready=%b, want 01", i, {busy, req_ready});
      end
    end
    checks++;
    if (strobes != s0) begin errors++; $display("FAIL zero_len_count: %0d strobes, want 0", strobes - s0); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midfill();
    int s0;
    writable = 1;
    req_addr = 12'h100; req_data = 8'h77; req_fill = 1; req_len = 12'd100; req_valid = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      req_addr = 12'h300 + 12'(k); req_data = 8'(k); req_fill = 0;
      @(posedge clk); #1;
    end
    req_valid = 0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    checks++;
    if ({write_enable, address} !== {1'b1, 12'h104}) begin
      errors++; $display("FAIL midfill_w5: we=%b addr=%h, want 1 104", write_enable, address);
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    checks++;
    if ({write_enable, busy, address, data, req_ready} !== {2'b00, 20'h0, 1'b1}) begin
      errors++;
      $display("FAIL midfill_rst: we=%b busy=%b addr=%h data=%h ready=%b, want 0 0 000 00 1",
               write_enable, busy, address, data, req_ready);
    end
    s0 = strobes;
    repeat (20) @(negedge clk);
    checks++;
    if (strobes != s0 || busy !== 1'b0) begin
      errors++; $display("FAIL midfill_quiet: %0d strobes busy=%b, want 0 0", strobes - s0, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    rand_wr = 1;
    for (int i = 0; i < 60; i++)
      send(12'($urandom), 8'($urandom), $urandom_range(0, 3) == 0, 12'($urandom_range(0, 6)));
    rand_wr = 0;
    @(posedge clk); #2 writable = 1;
    wait_idle("random");
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL random_drain: %0d bytes left, want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_clear();
    test_stall();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_reset_midfill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
